// File: rtl/tm_master_req_queue.sv
// tm_master_req_queue: request FIFO between a master and its credit/switch regulator
module tm_master_req_queue #(
  parameter int DEPTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ADDRESS_WIDTH = 4,
  parameter int VC_ADDRESS_WIDTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic [ADDRESS_WIDTH-1:0]    in_dest,
  input  logic [VC_ADDRESS_WIDTH-1:0] in_vc,
  output logic                        in_ready,
  output logic                        send_valid,
  output logic [DATA_WIDTH-1:0]       send_data,
  output logic [ADDRESS_WIDTH-1:0]    send_dest,
  output logic [VC_ADDRESS_WIDTH-1:0] send_vc,
  input  logic                        send_ready,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        head_switch
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [ADDRESS_WIDTH-1:0] mem_dest [DEPTH];
  logic [VC_ADDRESS_WIDTH-1:0] mem_vc [DEPTH];
  logic [ADDRESS_WIDTH-1:0] last_dest, head_dest;
  logic [VC_ADDRESS_WIDTH-1:0] last_vc, head_vc;
  logic empty, full, push, pop;
  always_comb begin
    empty = wr_ptr == rd_ptr;
    full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    push = in_valid && !full;
    pop = !empty && send_ready;
    head_dest = mem_dest[rd_ptr[AW-1:0]];
    head_vc = mem_vc[rd_ptr[AW-1:0]];
    in_ready = !full;
    send_valid = pop;
    send_data = mem_data[rd_ptr[AW-1:0]];
    send_dest = empty ? last_dest : head_dest;
    send_vc = empty ? last_vc : head_vc;
    count = wr_ptr - rd_ptr;
    head_switch = !empty && ({head_dest, head_vc} != {last_dest, last_vc});
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last_dest <= '0;
      last_vc <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_dest <= head_dest;
        last_vc <= head_vc;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr[AW-1:0]] <= in_data;
      mem_dest[wr_ptr[AW-1:0]] <= in_dest;
      mem_vc[wr_ptr[AW-1:0]] <= in_vc;
    end
  end
endmodule

// File: tb/tb_tm_master_req_queue.sv
// tb_tm_master_req_queue: directed table and sequence checks for tm_master_req_queue
module tb_tm_master_req_queue;
  logic clk = 0, rst = 1, in_valid = 0, send_ready = 0;
  logic [31:0] in_data = 0;
  logic [3:0] in_dest = 0;
  logic [1:0] in_vc = 0;
  logic in_ready, send_valid, head_switch;
  logic [31:0] send_data;
  logic [3:0] send_dest, count;
  logic [1:0] send_vc;
  int checks = 0, failures = 0;
  logic [31:0] q [$];
  typedef struct {
    logic rst, iv;
    logic [31:0] d;
    logic [3:0] dest;
    logic [1:0] vc;
    logic sr, e_rdy, e_sv;
    logic [31:0] e_d;
    logic [3:0] e_dest;
    logic [1:0] e_vc;
    logic [3:0] e_cnt;
    logic e_hs;
  } vec_t;
  vec_t vecs [16];
  tm_master_req_queue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_dest(in_dest),
    .in_vc(in_vc), .in_ready(in_ready), .send_valid(send_valid), .send_data(send_data),
    .send_dest(send_dest), .send_vc(send_vc), .send_ready(send_ready), .count(count),
    .head_switch(head_switch)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    #2;
    checks++;
    if (send_valid && !send_ready) begin
      failures++;
      $display("FAIL valid_without_ready actual=%0b required=0", send_valid);
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic step(input logic r, input logic iv, input logic [31:0] d, input logic [3:0] de,
                      input logic [1:0] v, input logic sr);
    @(negedge clk);
    rst = r;
    in_valid = iv;
    in_data = d;
    in_dest = de;
    in_vc = v;
    send_ready = sr;
    #1;
  endtask
  initial begin
    vecs[0]  = '{0, 0, 32'h0,  0, 0, 1, 1, 0, 32'h0,  0, 0, 0, 0};
    vecs[1]  = '{0, 1, 32'hA1, 3, 1, 1, 1, 0, 32'h0,  0, 0, 0, 0};
    vecs[2]  = '{0, 0, 32'h0,  0, 0, 1, 1, 1, 32'hA1, 3, 1, 1, 1};
    vecs[3]  = '{0, 0, 32'h0,  0, 0, 1, 1, 0, 32'h0,  3, 1, 0, 0};
    vecs[4]  = '{0, 1, 32'hB2, 2, 0, 0, 1, 0, 32'h0,  3, 1, 0, 0};
    vecs[5]  = '{0, 1, 32'hB5, 5, 0, 0, 1, 0, 32'h0,  2, 0, 1, 1};
    vecs[6]  = '{0, 0, 32'h0,  0, 0, 1, 1, 1, 32'hB2, 2, 0, 2, 1};
    vecs[7]  = '{0, 0, 32'h0,  0, 0, 0, 1, 0, 32'h0,  5, 0, 1, 1};
    vecs[8]  = '{0, 0, 32'h0,  0, 0, 1, 1, 1, 32'hB5, 5, 0, 1, 1};
    vecs[9]  = '{0, 0, 32'h0,  0, 0, 1, 1, 0, 32'h0,  5, 0, 0, 0};
    vecs[10] = '{0, 1, 32'hC0, 5, 0, 0, 1, 0, 32'h0,  5, 0, 0, 0};
    vecs[11] = '{0, 0, 32'h0,  0, 0, 0, 1, 0, 32'h0,  5, 0, 1, 0};
    vecs[12] = '{0, 1, 32'hD0, 5, 2, 1, 1, 1, 32'hC0, 5, 0, 1, 0};
    vecs[13] = '{0, 0, 32'h0,  0, 0, 0, 1, 0, 32'h0,  5, 2, 1, 1};
    vecs[14] = '{1, 0, 32'h0,  0, 0, 1, 1, 1, 32'hD0, 5, 2, 1, 1};
    vecs[15] = '{0, 0, 32'h0,  0, 0, 1, 1, 0, 32'h0,  0, 0, 0, 0};
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].iv, vecs[i].d, vecs[i].dest, vecs[i].vc, vecs[i].sr);
      chk($sformatf("v%0d_in_ready", i), in_ready, vecs[i].e_rdy);
      chk($sformatf("v%0d_send_valid", i), send_valid, vecs[i].e_sv);
      if (vecs[i].e_sv) chk($sformatf("v%0d_send_data", i), send_data, vecs[i].e_d);
      chk($sformatf("v%0d_send_dest", i), send_dest, vecs[i].e_dest);
      chk($sformatf("v%0d_send_vc", i), send_vc, vecs[i].e_vc);
      chk($sformatf("v%0d_count", i), count, vecs[i].e_cnt);
      chk($sformatf("v%0d_head_switch", i), head_switch, vecs[i].e_hs);
    end
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 100 + i, 4'(i), 2'(i), 0);
      chk("fill_count", count, i);
      q.push_back(100 + i);
    end
    step(0, 1, 999, 9, 3, 0);
    chk("full_count", count, 8);
    chk("full_in_ready", in_ready, 0);
    step(0, 1, 998, 9, 3, 1);
    chk("full_pop_valid", send_valid, 1);
    chk("full_pop_data", send_data, q.pop_front());
    chk("full_pop_count", count, 8);
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 0, 0, 0, 1);
      chk("drain_count", count, 7 - i);
      chk("drain_valid", send_valid, 1);
      chk("drain_data", send_data, q.pop_front());
    end
    step(0, 0, 0, 0, 0, 1);
    chk("drain_empty", count, 0);
    chk("drain_done_valid", send_valid, 0);
    chk("drain_dest_hold", send_dest, 7);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 200 + i, 4'(i + 1), 2'(i), 0);
      q.push_back(200 + i);
    end
    for (int i = 0; i < 30; i++) begin
      step(0, 1, 300 + i, 4'(i * 3), 2'(i), 1);
      chk("steady_count", count, 4);
      chk("steady_valid", send_valid, 1);
      chk("steady_data", send_data, q.pop_front());
      q.push_back(300 + i);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 1);
      chk("steady_drain_data", send_data, q.pop_front());
    end
    for (int i = 0; i < 5; i++) step(0, 1, 400 + i, 4'(i + 9), 1, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("pre_reset_count", count, 5);
    chk("pre_reset_dest", send_dest, 9);
    step(1, 1, 500, 6, 2, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("reset_count", count, 0);
    chk("reset_valid", send_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_dest", send_dest, 0);
    chk("reset_vc", send_vc, 0);
    chk("reset_head_switch", head_switch, 0);
    step(0, 0, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
